// File: rtl/tpram_stream_fifo.sv
// Valid/ready stream FIFO controller that drives an external two-port RAM
// (write port A, registered read port B). A 2-entry output buffer gives first-word-fall-through.
module tpram_stream_fifo #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW+1:0] level,
    output logic          wea,
    output logic [AW-1:0] addra,
    output logic [DW-1:0] data_i_a,
    output logic          enb,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] data_o_b
);

    localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_count;
    logic          rd_pending;
    logic [1:0]    buf_count;
    logic          head;
    logic [DW-1:0] buf_mem [2];

    logic          push;
    logic          pop;
    logic          issue;
    logic          tail;
    logic [2:0]    occ_next;

    assign in_ready  = (ram_count != FULL_COUNT);
    assign out_valid = (buf_count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Buffer occupancy after this cycle, counting a read already in flight;
    // a new read is only issued if its word will have a free slot on arrival.
    assign occ_next  = {1'b0, buf_count} + {2'b00, rd_pending} - {2'b00, pop};
    assign issue     = (ram_count != '0) && (occ_next <= 3'd1);
    assign tail      = head ^ buf_count[0];

    assign wea      = push;
    assign addra    = wr_ptr;
    assign data_i_a = in_data;
    assign enb      = issue;
    assign addrb    = rd_ptr;
    assign out_data = buf_mem[head];
    assign level    = {1'b0, ram_count}
                    + {{(AW+1){1'b0}}, rd_pending}
                    + {{AW{1'b0}}, buf_count};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_count  <= '0;
            rd_pending <= 1'b0;
            buf_count  <= 2'd0;
            head       <= 1'b0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (issue)
                rd_ptr <= rd_ptr + 1'b1;
            ram_count  <= ram_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};
            rd_pending <= issue;
            if (rd_pending)
                buf_mem[tail] <= data_o_b;
            if (pop)
                head <= ~head;
            buf_count  <= buf_count + {1'b0, rd_pending} - {1'b0, pop};
            if (rd_pending)
                assert (buf_count != 2'd2 || pop);
        end
    end

endmodule
